// File: rtl/data_cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package data_cache_pkg;

    localparam int unsigned TAG_W      = 3;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned BLOCK_W    = 32;
    localparam int unsigned BLOCKS     = 8;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int unsigned MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WRITE,
        MEM_READ,
        UPDATE
    } state_t;

endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage with hit compare, byte select, byte write and block refill.
module data_cache_array
    import data_cache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index,
    input  logic [TAG_W-1:0]    tag,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                byte_we,
    input  logic [BYTE_W-1:0]   byte_wdata,
    input  logic                fill_we,
    input  logic [BLOCK_W-1:0]  fill_data,
    output logic                hit,
    output logic [BYTE_W-1:0]   rd_byte,
    output logic [TAG_W-1:0]    victim_tag,
    output logic                victim_dirty,
    output logic [BLOCK_W-1:0]  block_data
);

    logic [BLOCK_W-1:0] data_q [BLOCKS];
    logic [TAG_W-1:0]   tag_q  [BLOCKS];
    logic [BLOCKS-1:0]  valid_q;
    logic [BLOCKS-1:0]  dirty_q;

    // Valid/dirty bits: cleared by reset, refill makes a block valid and clean, a store dirties it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Data and tag storage; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clock) begin
        if (fill_we) begin
            data_q[index] <= fill_data;
            tag_q[index]  <= tag;
        end else if (byte_we) begin
            data_q[index][{offset, 3'b000} +: BYTE_W] <= byte_wdata;
        end
    end

    assign block_data   = data_q[index];
    assign victim_tag   = tag_q[index];
    assign victim_dirty = valid_q[index] & dirty_q[index];
    assign hit          = valid_q[index] && (tag_q[index] == tag);
    assign rd_byte      = block_data[{offset, 3'b000} +: BYTE_W];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate byte cache in front of a 32-bit block memory.
module data_cache
    import data_cache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [BYTE_W-1:0]     writedata,
    output logic [BYTE_W-1:0]     readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    state_t state, next_state;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                request;

    logic                hit;
    logic [BYTE_W-1:0]   rd_byte;
    logic [TAG_W-1:0]    victim_tag;
    logic                victim_dirty;
    logic [BLOCK_W-1:0]  block_data;
    logic                byte_we;
    logic                fill_we;

    assign req_tag    = address[ADDR_W-1 -: TAG_W];
    assign req_index  = address[OFFSET_W +: INDEX_W];
    assign req_offset = address[OFFSET_W-1:0];
    assign request    = read | write;

    data_cache_array u_array (
        .clock        (clock),
        .reset        (reset),
        .index        (req_index),
        .tag          (req_tag),
        .offset       (req_offset),
        .byte_we      (byte_we),
        .byte_wdata   (writedata),
        .fill_we      (fill_we),
        .fill_data    (mem_readdata),
        .hit          (hit),
        .rd_byte      (rd_byte),
        .victim_tag   (victim_tag),
        .victim_dirty (victim_dirty),
        .block_data   (block_data)
    );

    // Miss-handling state register; reset abandons any memory transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; hits are served combinationally from IDLE.
    always_comb begin
        next_state    = state;
        busywait      = 1'b0;
        readdata      = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        byte_we       = 1'b0;
        fill_we       = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        byte_we = write;
                        if (read && !write) begin
                            readdata = rd_byte;
                        end
                    end else begin
                        busywait   = 1'b1;
                        next_state = victim_dirty ? MEM_WRITE : MEM_READ;
                    end
                end
            end
            MEM_WRITE: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {victim_tag, req_index};
                mem_writedata = block_data;
                if (!mem_busywait) begin
                    next_state = MEM_READ;
                end
            end
            MEM_READ: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {req_tag, req_index};
                if (!mem_busywait) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                busywait   = 1'b1;
                fill_we    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed table, reset corner cases, randomized ops vs a flat-memory model.
module tb_data_cache;

    logic        clock = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_cmp = 0;
    int n_err = 0;

    data_cache dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    // Block memory: busy for mem_lat cycles per access, read data held until the next read completes.
    logic [31:0] mem_words [64];
    logic [31:0] rdata_q;
    int unsigned mcnt;
    int unsigned mem_lat;
    logic        mem_init;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'hDDCCBBAA;
        return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    endfunction

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_words[i] <= init_word(i);
            mcnt <= 0;
        end else if (mem_read || mem_write) begin
            if (mcnt >= mem_lat) begin
                mcnt <= 0;
                if (mem_write) mem_words[mem_address] <= mem_writedata;
                else           rdata_q <= mem_words[mem_address];
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (mcnt < mem_lat);
    assign mem_readdata = rdata_q;

    // Reference: the cache+memory pair behaves as a flat byte memory; tags only predict traffic.
    logic [7:0] ref_bytes [256];
    logic       m_valid [8];
    logic [2:0] m_tag   [8];
    logic       m_dirty [8];

    typedef struct {
        logic        stall;
        int          wb_n;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        int          rd_n;
        logic [5:0]  rd_addr;
        logic [7:0]  rdata;
        logic        both;
        logic        done;
    } res_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        stall;
        int          wb_n;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        int          rd_n;
        logic [5:0]  rd_addr;
        logic        chk;
        logic [7:0]  rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 256; a++) ref_bytes[a] = mem_words[a/4][8*(a%4) +: 8];
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 3'd0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Present one request and hold it until busywait drops, recording memory traffic on the way.
    task automatic do_op(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, output res_t r);
        logic prev_w, prev_r;
        int   cyc;
        @(negedge clock);
        read = rd; write = wr; address = addr; writedata = wdata;
        #1;
        r.stall = busywait; r.wb_n = 0; r.rd_n = 0; r.both = 1'b0; r.done = 1'b1;
        r.wb_addr = '0; r.wb_data = '0; r.rd_addr = '0;
        prev_w = 1'b0; prev_r = 1'b0; cyc = 0;
        while (busywait && r.done) begin
            if (mem_write && !prev_w) r.wb_n++;
            if (mem_read && !prev_r)  r.rd_n++;
            if (mem_write) begin r.wb_addr = mem_address; r.wb_data = mem_writedata; end
            if (mem_read)  r.rd_addr = mem_address;
            if (mem_read && mem_write) r.both = 1'b1;
            prev_w = mem_write; prev_r = mem_read;
            @(negedge clock); #1;
            cyc++;
            if (cyc > 60) r.done = 1'b0;
        end
        r.rdata = readdata;
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
    endtask

    vec_t vecs [12];
    res_t r;

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        mem_init = 1'b1; mem_lat = 2;
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 0, 6'h00, 32'h0,        1, 6'h01, 1'b1, 8'hBB};
        vecs[1]  = '{1'b0, 1'b1, 8'h06, 8'h7E, 1'b0, 0, 6'h00, 32'h0,        0, 6'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 0, 6'h00, 32'h0,        0, 6'h00, 1'b1, 8'h7E};
        vecs[3]  = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b1, 1, 6'h01, 32'hDD7EBBAA, 1, 6'h09, 1'b1, 8'h25};
        vecs[4]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 0, 6'h00, 32'h0,        1, 6'h01, 1'b1, 8'hBB};
        vecs[5]  = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 0, 6'h00, 32'h0,        0, 6'h00, 1'b1, 8'h7E};
        vecs[6]  = '{1'b0, 1'b1, 8'h10, 8'h11, 1'b1, 0, 6'h00, 32'h0,        1, 6'h04, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 0, 6'h00, 32'h0,        0, 6'h00, 1'b1, 8'h11};
        vecs[8]  = '{1'b1, 1'b0, 8'h13, 8'h00, 1'b0, 0, 6'h00, 32'h0,        0, 6'h00, 1'b1, 8'h13};
        vecs[9]  = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 0, 6'h00, 32'h0,        0, 6'h00, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 0, 6'h00, 32'h0,        0, 6'h00, 1'b1, 8'h22};
        vecs[11] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1, 6'h04, 32'h13122211, 1, 6'h0C, 1'b1, 8'h30};

        repeat (2) @(negedge clock);
        mem_init = 1'b0;
        #1;
        check("reset_busywait",      32'(busywait),      32'h0);
        check("reset_mem_read",      32'(mem_read),      32'h0);
        check("reset_mem_write",     32'(mem_write),     32'h0);
        check("reset_mem_address",   32'(mem_address),   32'h0);
        check("reset_mem_writedata", mem_writedata,      32'h0);
        check("reset_readdata",      32'(readdata),      32'h0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Directed table: cold read, write hit, dirty and clean evictions, write miss, read+write.
        for (int v = 0; v < 12; v++) begin
            do_op(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, r);
            check($sformatf("vec%0d_done", v),  32'(r.done),  32'h1);
            check($sformatf("vec%0d_stall", v), 32'(r.stall), 32'(vecs[v].stall));
            check($sformatf("vec%0d_wb_n", v),  32'(r.wb_n),  32'(vecs[v].wb_n));
            check($sformatf("vec%0d_rd_n", v),  32'(r.rd_n),  32'(vecs[v].rd_n));
            check($sformatf("vec%0d_both", v),  32'(r.both),  32'h0);
            if (vecs[v].wb_n > 0) begin
                check($sformatf("vec%0d_wb_addr", v), 32'(r.wb_addr), 32'(vecs[v].wb_addr));
                check($sformatf("vec%0d_wb_data", v), r.wb_data,       vecs[v].wb_data);
            end
            if (vecs[v].rd_n > 0)
                check($sformatf("vec%0d_rd_addr", v), 32'(r.rd_addr), 32'(vecs[v].rd_addr));
            if (vecs[v].chk)
                check($sformatf("vec%0d_rdata", v), 32'(r.rdata), 32'(vecs[v].rdata));
        end

        // Reset during MEM_READ: memory request drops at once and the refill is discarded.
        apply_reset();
        mem_lat = 20;
        @(negedge clock);
        read = 1'b1; address = 8'h05;
        begin
            int w;
            w = 0;
            #1;
            while (!mem_read && w < 10) begin
                @(negedge clock); #1;
                w++;
            end
            check("midmiss_saw_mem_read", 32'(mem_read), 32'h1);
        end
        @(negedge clock);
        reset = 1'b1; read = 1'b0;
        #1;
        check("midmiss_mem_read",  32'(mem_read),  32'h0);
        check("midmiss_busywait",  32'(busywait),  32'h0);
        check("midmiss_mem_write", 32'(mem_write), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        mem_lat = 1;
        do_op(1'b1, 1'b0, 8'h05, 8'h00, r);
        check("reread_done",  32'(r.done),  32'h1);
        check("reread_stall", 32'(r.stall), 32'h1);
        check("reread_rd_n",  32'(r.rd_n),  32'h1);
        check("reread_rdata", 32'(r.rdata), 32'(ref_bytes[8'h05]));

        // Randomized ops against the flat-memory model.
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a, wd;
            logic       rd, wr, hit, wb;
            logic [2:0] idx, tg;
            logic [31:0] exp_blk;
            int op;
            mem_lat = $urandom_range(0, 3);
            op = $urandom_range(0, 2);
            rd = (op != 1);
            wr = (op != 0);
            a  = 8'($urandom);
            wd = 8'($urandom);
            idx = a[4:2];
            tg  = a[7:5];
            hit = m_valid[idx] && (m_tag[idx] == tg);
            wb  = !hit && m_valid[idx] && m_dirty[idx];
            for (int k = 0; k < 4; k++) exp_blk[8*k +: 8] = ref_bytes[{m_tag[idx], idx, 2'(k)}];
            do_op(rd, wr, a, wd, r);
            check("rnd_done",  32'(r.done),  32'h1);
            check("rnd_stall", 32'(r.stall), 32'(!hit));
            check("rnd_wb_n",  32'(r.wb_n),  32'(wb));
            check("rnd_rd_n",  32'(r.rd_n),  32'(!hit));
            check("rnd_both",  32'(r.both),  32'h0);
            if (wb) begin
                check("rnd_wb_addr", 32'(r.wb_addr), 32'({m_tag[idx], idx}));
                check("rnd_wb_data", r.wb_data, exp_blk);
            end
            if (!hit) check("rnd_rd_addr", 32'(r.rd_addr), 32'({tg, idx}));
            if (rd && !wr) check("rnd_rdata", 32'(r.rdata), 32'(ref_bytes[a]));
            if (!hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_dirty[idx] = 1'b0;
            end
            if (wr) begin
                m_dirty[idx] = 1'b1;
                ref_bytes[a] = wd;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
